fp_alu_frame_ctrl: RTL and testbench

//  Parametrised UART framing controller for the FP ALU. Collects operand A, operand B and an op byte from

---
 rtl/fp_alu_frame_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_fp_alu_frame_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fp_alu_frame_ctrl
//  Purpose  : UART framing controller for the FP ALU. Collects operand A,
//             operand B and an op byte, runs the ALU, and returns the result
//             MSB-first. Define FRAME_CKSUM_EN to add a trailing XOR
//             checksum byte to each frame.
//  Revision : 1.0  initial release
// ============================================================================
module fp_alu_frame_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ALU_LAT     = 0,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_opcode,
    output logic              alu_addsub,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              frame_err,
    output logic              rx_drop
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(ALU_LAT + NBYTES + 2) + 1;
    localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [CNT_W-1:0] c_last_byte = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] c_last_lat  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] c_first_cnt = CNT_W'((NBYTES == 1) ? 0 : 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_A    = 3'd1,
        S_RX_B    = 3'd2,
        S_RX_OP   = 3'd3,
        S_RX_CK   = 3'd4,
        S_EXEC    = 3'd5,
        S_TX_LOAD = 3'd6,
        S_TX_WAIT = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_tx_last;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_sh_a;
    logic [DATA_W-1:0] r_sh_b;
    logic [DATA_W-1:0] r_tx_sh;
    logic              r_busy_seen;
    logic              w_in_rx;
    logic              w_in_xfer;
    logic              w_to_expire;
`ifdef FRAME_CKSUM_EN
    localparam logic [7:0] c_err_byte = 8'hEE;
    logic [2:0]        r_op;
    logic [7:0]        r_ck;
`endif

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                   input logic [7:0]        b);
        logic [DATA_W+7:0] t;
        t = {cur, b};
        return t[DATA_W-1:0];
    endfunction

    assign w_in_rx   = (r_state == S_RX_A) || (r_state == S_RX_B) ||
                       (r_state == S_RX_OP) || (r_state == S_RX_CK);
    assign w_in_xfer = (r_state == S_EXEC) || (r_state == S_TX_LOAD) ||
                       (r_state == S_TX_WAIT);
    assign busy      = (r_state != S_IDLE);

    // A byte arriving on the expiry cycle keeps the frame alive.
    generate
        if (TIMEOUT_CYC == 0) begin : g_no_timeout
            assign w_to_expire = 1'b0;
        end else begin : g_timeout
            assign w_to_expire = w_in_rx && !rx_done &&
                                 (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (rx_done) w_state_next = (NBYTES == 1) ? S_RX_B : S_RX_A;
            S_RX_A:    if (rx_done && r_cnt == c_last_byte) w_state_next = S_RX_B;
            S_RX_B:    if (rx_done && r_cnt == c_last_byte) w_state_next = S_RX_OP;
`ifdef FRAME_CKSUM_EN
            S_RX_OP:   if (rx_done) w_state_next = S_RX_CK;
            S_RX_CK:   if (rx_done) w_state_next = (rx_data == r_ck) ? S_EXEC : S_TX_LOAD;
`else
            S_RX_OP:   if (rx_done) w_state_next = S_EXEC;
`endif
            S_EXEC:    if (r_cnt == c_last_lat) w_state_next = S_TX_LOAD;
            S_TX_LOAD: if (!tx_busy) w_state_next = S_TX_WAIT;
            S_TX_WAIT: if (r_busy_seen && !tx_busy)
                           w_state_next = (r_cnt == r_tx_last) ? S_IDLE : S_TX_LOAD;
            default:   w_state_next = S_IDLE;
        endcase
        if (w_to_expire) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_tx_last   <= '0;
            r_to_cnt    <= '0;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_tx_sh     <= '0;
            r_busy_seen <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            alu_addsub  <= 1'b0;
            frame_err   <= 1'b0;
            rx_drop     <= 1'b0;
`ifdef FRAME_CKSUM_EN
            r_op        <= '0;
            r_ck        <= '0;
`endif
        end else begin
            tx_start  <= 1'b0;
            frame_err <= w_to_expire;
            rx_drop   <= rx_done && w_in_xfer;

            if (!w_in_rx || rx_done || w_to_expire) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: if (rx_done) begin
                    r_sh_a <= shift_in(r_sh_a, rx_data);
                    r_cnt  <= c_first_cnt;
`ifdef FRAME_CKSUM_EN
                    r_ck   <= rx_data;
`endif
                end
                S_RX_A: if (rx_done) begin
                    r_sh_a <= shift_in(r_sh_a, rx_data);
                    r_cnt  <= (r_cnt == c_last_byte) ? '0 : r_cnt + 1'b1;
`ifdef FRAME_CKSUM_EN
                    r_ck   <= r_ck ^ rx_data;
`endif
                end
                S_RX_B: if (rx_done) begin
                    r_sh_b <= shift_in(r_sh_b, rx_data);
                    r_cnt  <= (r_cnt == c_last_byte) ? '0 : r_cnt + 1'b1;
`ifdef FRAME_CKSUM_EN
                    r_ck   <= r_ck ^ rx_data;
`endif
                end
`ifdef FRAME_CKSUM_EN
                S_RX_OP: if (rx_done) begin
                    r_op  <= rx_data[2:0];
                    r_ck  <= r_ck ^ rx_data;
                    r_cnt <= '0;
                end
                S_RX_CK: if (rx_done) begin
                    r_cnt <= '0;
                    if (rx_data == r_ck) begin
                        alu_a      <= r_sh_a;
                        alu_b      <= r_sh_b;
                        alu_opcode <= r_op[1:0];
                        alu_addsub <= r_op[2];
                    end else begin
                        // Bad checksum: report and answer with a single error byte.
                        frame_err <= 1'b1;
                        r_tx_sh   <= DATA_W'(c_err_byte) << (DATA_W - 8);
                        r_tx_last <= '0;
                    end
                end
`else
                S_RX_OP: if (rx_done) begin
                    alu_a      <= r_sh_a;
                    alu_b      <= r_sh_b;
                    alu_opcode <= rx_data[1:0];
                    alu_addsub <= rx_data[2];
                    r_cnt      <= '0;
                end
`endif
                S_EXEC: begin
                    if (r_cnt == c_last_lat) begin
                        r_tx_sh   <= alu_result;
                        r_tx_last <= c_last_byte;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TX_LOAD: if (!tx_busy) begin
                    tx_data  <= r_tx_sh[DATA_W-1 -: 8];
                    tx_start <= 1'b1;
                end
                S_TX_WAIT: begin
                    if (tx_busy) r_busy_seen <= 1'b1;
                    if (r_busy_seen && !tx_busy) begin
                        r_busy_seen <= 1'b0;
                        r_tx_sh     <= r_tx_sh << 8;
                        r_cnt       <= (r_cnt == r_tx_last) ? '0 : r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_to_expire) r_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_alu_frame_ctrl
//  Purpose  : Self-checking bench for fp_alu_frame_ctrl with a pipelined
//             stand-in ALU and a byte-level uart_tx model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_alu_frame_ctrl;

    localparam int DATA_W      = 32;
    localparam int NBYTES      = DATA_W / 8;
    localparam int ALU_LAT     = 3;
    localparam int TIMEOUT_CYC = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_done = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_opcode;
    logic              alu_addsub;
    logic [DATA_W-1:0] alu_result;
    logic              busy;
    logic              frame_err;
    logic              rx_drop;

    always #5 clk = ~clk;

    fp_alu_frame_ctrl #(
        .DATA_W      (DATA_W),
        .ALU_LAT     (ALU_LAT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_addsub (alu_addsub),
        .alu_result (alu_result),
        .busy       (busy),
        .frame_err  (frame_err),
        .rx_drop    (rx_drop)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [1:0]        opc,
                                                 input logic              sub);
        case (opc)
            2'd0:    alu_fn = sub ? a - b : a + b;
            2'd1:    alu_fn = sub ? ~(a & b) : (a & b);
            2'd2:    alu_fn = a | b;
            default: alu_fn = a ^ b;
        endcase
    endfunction

    // Stand-in ALU: result becomes valid ALU_LAT cycles after its inputs change.
    logic [DATA_W-1:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_a, alu_b, alu_opcode, alu_addsub);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1];

    // uart_tx model and pulse monitors.
    logic [7:0] tx_q [$];
    int   first_tx_cyc = -1;
    int   n_err = 0, err_cyc = 0, n_drop = 0, proto_err = 0, busy_left = 0;
    logic hold_busy = 1'b0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_err) begin n_err++; err_cyc = cyc; end
            if (rx_drop) n_drop++;
            if (tx_start) begin
                if (tx_busy || busy_left != 0) proto_err++;
                if (tx_q.size() == 0) first_tx_cyc = cyc;
                tx_q.push_back(tx_data);
                busy_left = int'($urandom_range(1, 4));
            end else if (busy_left != 0) begin
                busy_left--;
            end
            tx_busy = hold_busy || (busy_left != 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [DATA_W-1:0] exp_a = '0, exp_b = '0;
    logic [1:0]        exp_opc = '0;
    logic              exp_as = 1'b0;
    int                last_rx_cyc = 0, op_cyc = 0;
`ifdef FRAME_CKSUM_EN
    logic [7:0]        ck_flip = 8'h00;
`endif

    // Called at a negedge; returns at a negedge after `gap` idle rx cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        last_rx_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic [7:0] op, input int stall_idx);
        logic [7:0] bytes [$];
        for (int i = NBYTES-1; i >= 0; i--) bytes.push_back(a[i*8 +: 8]);
        for (int i = NBYTES-1; i >= 0; i--) bytes.push_back(b[i*8 +: 8]);
        bytes.push_back(op);
`ifdef FRAME_CKSUM_EN
        begin
            logic [7:0] ck;
            ck = 8'h00;
            foreach (bytes[i]) ck ^= bytes[i];
            bytes.push_back(ck ^ ck_flip);
        end
`endif
        for (int i = 0; i < bytes.size(); i++)
            send_byte(bytes[i], (i == bytes.size()-1) ? 0 :
                                (i == stall_idx) ? TIMEOUT_CYC-1 :
                                int'($urandom_range(1, 5)));
        op_cyc = last_rx_cyc;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin @(negedge clk); k++; end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || tx_busy) && k < budget) begin @(negedge clk); k++; end
        check("idle_reached", {62'd0, busy, tx_busy}, 64'd0);
    endtask

    task automatic run_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic [7:0] op, input int stall_idx,
                             input bit inject, input bit hold);
        logic [DATA_W-1:0] exp_r;
        int err0, drop0;
        wait_idle(200);
        tx_q.delete();
        first_tx_cyc = -1;
        err0  = n_err;
        drop0 = n_drop;
        hold_busy = hold;
        send_frame(a, b, op, stall_idx);
        if (inject) send_byte(8'($urandom), 0);
        if (hold) begin
            repeat (50) @(negedge clk);
            check("held_no_strobe", tx_q.size(), 0);
            check("held_busy", busy, 1);
            hold_busy = 1'b0;
        end
        exp_a   = a;
        exp_b   = b;
        exp_opc = op[1:0];
        exp_as  = op[2];
        exp_r   = alu_fn(a, b, op[1:0], op[2]);
        wait_tx(NBYTES, 60 * NBYTES);
        wait_idle(200);
        check("alu_a", alu_a, exp_a);
        check("alu_b", alu_b, exp_b);
        check("alu_opcode", alu_opcode, exp_opc);
        check("alu_addsub", alu_addsub, exp_as);
        check("tx_count", tx_q.size(), NBYTES);
        for (int i = 0; i < NBYTES; i++)
            check($sformatf("tx_byte%0d", i),
                  (i < tx_q.size()) ? {56'd0, tx_q[i]} : 64'h100,
                  exp_r[(NBYTES-1-i)*8 +: 8]);
        if (!hold) check("first_tx_latency", first_tx_cyc - op_cyc, ALU_LAT + 2);
        check("rx_drop_count", n_drop - drop0, inject ? 1 : 0);
        check("no_frame_err", n_err - err0, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int k, err0, n0;
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, err0, n0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_opcode", {alu_opcode, alu_addsub}, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {frame_err, rx_drop}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed add and sub frames, the sub with a byte dropped during EXEC.
        run_frame(32'h3F80_0000, 32'h4000_0000, 8'h00, -1, 1'b0, 1'b0);
        run_frame(32'h3F80_0000, 32'h4000_0000, 8'h04, -1, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++)
            run_frame($urandom, $urandom, 8'($urandom), -1, 1'($urandom), 1'b0);

        // Inter-byte timeout: three bytes then silence.
        wait_idle(200);
        tx_q.delete();
        err0 = n_err;
        send_byte(8'($urandom), 1);
        send_byte(8'($urandom), 1);
        send_byte(8'($urandom), 0);
        k = 0;
        while (n_err == err0 && k < 3 * TIMEOUT_CYC) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        check("timeout_err_count", n_err - err0, 1);
        check("timeout_err_cycle", err_cyc - last_rx_cyc, TIMEOUT_CYC);
        check("timeout_idle", busy, 0);
        check("timeout_alu_a_kept", alu_a, exp_a);
        check("timeout_alu_b_kept", alu_b, exp_b);
        check("timeout_no_tx", tx_q.size(), 0);
        run_frame($urandom, $urandom, 8'($urandom), -1, 1'b0, 1'b0);

        // A byte landing exactly on the expiry cycle keeps the frame alive.
        run_frame($urandom, $urandom, 8'($urandom), 2, 1'b0, 1'b0);

        // Receiver held busy well past result-ready.
        run_frame($urandom, $urandom, 8'h01, -1, 1'b0, 1'b1);

`ifdef FRAME_CKSUM_EN
        wait_idle(200);
        tx_q.delete();
        err0 = n_err;
        ck_flip = 8'h5A;
        send_frame($urandom, $urandom, 8'($urandom), -1);
        ck_flip = 8'h00;
        wait_tx(1, 200);
        wait_idle(200);
        check("cksum_err", n_err - err0, 1);
        check("cksum_tx_count", tx_q.size(), 1);
        check("cksum_tx_byte", (tx_q.size() > 0) ? {56'd0, tx_q[0]} : 64'h100, 8'hEE);
        check("cksum_alu_a_kept", alu_a, exp_a);
        check("cksum_alu_b_kept", alu_b, exp_b);
`endif

        // Reset in the middle of result transmission.
        wait_idle(200);
        tx_q.delete();
        err0 = n_err;
        send_frame($urandom, $urandom, 8'($urandom), -1);
        k = 0;
        while (tx_q.size() < 2 && k < 400) begin @(negedge clk); k++; end
        check("pre_reset_bytes", tx_q.size(), 2);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_tx", {tx_start, tx_data}, 0);
        check("midrst_alu", {alu_a, alu_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = tx_q.size();
        repeat (30) @(negedge clk);
        check("post_reset_quiet", tx_q.size(), n0);
        check("post_reset_no_err", n_err - err0, 0);
        run_frame($urandom, $urandom, 8'($urandom), -1, 1'b0, 1'b0);

        check("tx_protocol", proto_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
